// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin arbiter for four sources sharing one transmitter.
// A grant loads the winner's payload and holds it until the transmitter
// handshakes or the wait budget expires, then pulses ack or err back to the
// winner. Every output is registered.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   req       in   [3:0] per-source request, held until ack/err
//   data0..3  in   [DATA_W-1:0] per-source payload
//   sel       out  [1:0] index of the granted source (holds outside XFER)
//   gnt       out  [3:0] one-hot grant
//   tx_data   out  [DATA_W-1:0] payload to the transmitter
//   tx_valid  out  transmit request
//   tx_ready  in   transmitter accepts when tx_valid & tx_ready
//   ack       out  [3:0] one-cycle completion pulse
//   err       out  [3:0] one-cycle timeout pulse
//   busy      out  high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a request, arbitrates on the next edge
// XFER  | payload presented, waiting for tx_ready or timeout
// DONE  | ack/err pulse cycle, gives the requester time to drop req
module mux_rr_sched #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  output logic [1:0]        sel,
  output logic [3:0]        gnt,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        ack,
  output logic [3:0]        err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [3:0]        ack_q, ack_d;
  logic [3:0]        err_q, err_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        win;
  logic [1:0]        idx;
  logic              found;
  logic [DATA_W-1:0] win_data;

  // Search starts one past the last served source so every requester is
  // reached within four grants.
  always_comb begin
    win   = ptr_q + 2'd1;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (win)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data3;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cnt_d      = cnt_q;
    ack_d      = 4'b0000;
    err_d      = 4'b0000;
    case (state_q)
      IDLE: begin
        gnt_d      = 4'b0000;
        tx_valid_d = 1'b0;
        if (|req) begin
          sel_d      = win;
          gnt_d      = 4'b0001 << win;
          tx_data_d  = win_data;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        // Handshake is checked first so it wins on the timeout cycle.
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          gnt_d      = 4'b0000;
          ack_d      = gnt_q;
          ptr_d      = sel_q;
          state_d    = DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          tx_valid_d = 1'b0;
          gnt_d      = 4'b0000;
          err_d      = gnt_q;
          ptr_d      = sel_q;
          state_d    = DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      sel_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ack_q      <= 4'b0000;
      err_q      <= 4'b0000;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sel      = sel_q;
  assign gnt      = gnt_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: doc/mux_rr_sched.md
MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 The parameter list SHALL be: DATA_W, default 8, data width of each source and of the transmit path.
REQ-002 The parameter list SHALL be: TIMEOUT, default 255, maximum XFER cycles to wait for tx_ready; 0 disables the timeout.
REQ-003 The port list SHALL be: clk  input  1  single clock, all logic on its rising edge.
REQ-004 The port list SHALL be: reset  input  1  synchronous, active-high reset.
REQ-005 The port list SHALL be: req  input  4  per-source request, bit i belongs to source i; held high until ack[i] or err[i].
REQ-006 The port list SHALL be: data0..data3  input  DATA_W each  source payloads, stable while the matching req is high.
REQ-007 The port list SHALL be: sel  output  2  select code driving the shared 4:1 mux; equals the index of the granted source.
REQ-008 The port list SHALL be: gnt  output  4  one-hot grant, all zero when no source is granted.
REQ-009 The port list SHALL be: tx_data  output  DATA_W  payload registered from the granted source.
REQ-010 The port list SHALL be: tx_valid  output  1  transmit request to the shared UART transmitter.
REQ-011 The port list SHALL be: tx_ready  input  1  transmitter accepts tx_data on a cycle where tx_valid and tx_ready are both high.
REQ-012 The port list SHALL be: ack  output  4  one-cycle completion pulse to the granted source.
REQ-013 The port list SHALL be: err  output  4  one-cycle timeout pulse to the granted source.
REQ-014 The port list SHALL be: busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states, IDLE, XFER and DONE, encoded in registers, and all outputs SHALL be registered.
REQ-016 In IDLE with req != 0, the next edge SHALL:
- select the winner by round-robin: search from (ptr+1) mod 4 upward with wrap, first set req bit wins;
- load sel = winner, gnt = one-hot(winner), tx_data = data[winner], tx_valid = 1, timeout counter = 0;
- enter XFER.
REQ-017 In IDLE with req == 0, the FSM SHALL stay in IDLE with gnt, tx_valid, ack and err all 0.
REQ-018 In XFER, a handshake (tx_valid & tx_ready) SHALL, on the next edge:
- clear tx_valid and gnt;
- pulse ack[winner] for exactly one cycle;
- set ptr = winner;
- enter DONE.
REQ-019 In XFER without a handshake, the FSM SHALL hold tx_valid, tx_data, sel and gnt stable and increment the counter, which saturates at TIMEOUT.
REQ-020 When TIMEOUT != 0 and the counter equals TIMEOUT-1 with no handshake, the next edge SHALL clear tx_valid and gnt, pulse err[winner] instead of ack, set ptr = winner and enter DONE.
REQ-021 A handshake on the cycle the timeout is reached SHALL take priority: ack is pulsed and err is not.
REQ-022 DONE SHALL last exactly one cycle and then enter IDLE, so a requester has one cycle after ack/err to drop req before re-arbitration.
REQ-023 sel SHALL hold its last value outside XFER, and the minimum transfer period SHALL be 3 cycles (IDLE -> XFER -> DONE) when tx_ready is already high.
REQ-024 Changes to req in XFER or DONE SHALL NOT affect the current grant.
REQ-025 ack and err SHALL never both be high, and at most one bit of each SHALL be high at a time.

Reset
REQ-026 When reset is high at a clock edge, the block SHALL set state = IDLE, ptr = 3 (source 0 has highest priority first), sel = 0, gnt = 0, tx_data = 0, tx_valid = 0, ack = 0, err = 0, busy = 0 and counter = 0.
REQ-027 Reset asserted mid-XFER SHALL abort the transfer with no ack and no err pulse, and reset SHALL take priority over all other inputs.

Verification
REQ-028 The bench SHALL cover a single request: reset, req=0010, data1=8'hA5, tx_ready=1 -> next cycle sel=1, gnt=0010, tx_valid=1, tx_data=A5; following cycle ack=0010; then IDLE.
REQ-029 The bench SHALL cover fairness: req=1111 held, tx_ready=1, each source drops req one cycle after its ack -> grant order 0,1,2,3, 3 cycles apart.
REQ-030 The bench SHALL cover wrap: ptr=2 after serving source 2, req=1001 -> source 3 granted, then source 0.
REQ-031 The bench SHALL cover backpressure: TIMEOUT=4, req=0100, tx_ready=0 -> tx_valid high for 4 cycles, then err=0100 for one cycle, then IDLE, no ack.
REQ-032 The bench SHALL cover a handshake exactly on the timeout cycle: tx_ready=1 on the 4th XFER cycle -> ack=0100 pulses and err stays 0.
REQ-033 The bench SHALL cover reset mid-transfer: reset in the 2nd XFER cycle -> next cycle all outputs 0, no ack/err, and a subsequent req=1111 grants source 0 first.
